pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives the per-stage `stall`/`clr` inputs of the pipeline registers:
- inserts load-use bubbles,
- flushes wrong-path instructions on a taken branch,
- sequences a multi-cycle execution unit (mul/div) sitting beside the EX ALU through a start/done handshake with timeout.
It also keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/sequencing controller.
// The controller takes the master modport; the datapath side (or a bench) takes slave.
`ifndef PIPE_CTRL_DEFS
`define PIPE_CTRL_DEFS
`define REG_IDX_W 5
`define DEST_SRC_W 2
`define DEST_SRC_MEM 2'd1
`endif

interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [`REG_IDX_W-1:0]  id_rs1;
    logic [`REG_IDX_W-1:0]  id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic [`DEST_SRC_W-1:0] ex_dest_src;
    logic [`REG_IDX_W-1:0]  ex_dest_reg;
    logic                   ex_br_taken;
    logic                   ex_mc;
    logic                   mc_done;
    logic                   mc_start;
    logic                   stall_if;
    logic                   stall_id;
    logic                   stall_ex;
    logic                   clr_id;
    logic                   clr_ex;
    logic                   clr_mem;
    logic                   mc_err;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_dest_src, ex_dest_reg, ex_br_taken, ex_mc, mc_done,
        output mc_start, stall_if, stall_id, stall_ex,
        output clr_id, clr_ex, clr_mem, mc_err, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_dest_src, ex_dest_reg, ex_br_taken, ex_mc, mc_done,
        input  mc_start, stall_if, stall_id, stall_ex,
        input  clr_id, clr_ex, clr_mem, mc_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle unit start/done/timeout, and perf counters.
`ifndef PIPE_CTRL_DEFS
`define PIPE_CTRL_DEFS
`define REG_IDX_W 5
`define DEST_SRC_W 2
`define DEST_SRC_MEM 2'd1
`endif

module pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          clr,
    pipe_ctrl_if.master   bus
);
    localparam int TW = $clog2(MC_TIMEOUT) + 1;

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic timeout_now;
    logic mc_start, stall_if, stall_id, stall_ex, clr_id, clr_ex, clr_mem;

    assign load_use = (bus.ex_dest_src == `DEST_SRC_MEM) && (bus.ex_dest_reg != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_dest_reg)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_dest_reg)));

    // Timeout is reported in the cycle it happens, not just from the next one.
    assign timeout_now = !clr && (state_q == MC_WAIT) && !bus.mc_done &&
                         (tcnt_q >= TW'(MC_TIMEOUT));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= RUN;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q | timeout_now;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mc_start    = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        clr_id      = 1'b0;
        clr_ex      = 1'b0;
        clr_mem     = 1'b0;

        if (clr) begin
            clr_id  = 1'b1;
            clr_ex  = 1'b1;
            clr_mem = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        clr_id = 1'b1;
                        clr_ex = 1'b1;
                        if (flush_cnt_q != {CNT_W{1'b1}})
                            flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    end else if (bus.ex_mc) begin
                        mc_start = 1'b1;
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                        clr_mem  = 1'b1;
                        state_d  = MC_WAIT;
                        tcnt_d   = TW'(1);
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        clr_ex   = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Done and timeout both release EX so its result moves on to MEM.
                    if (bus.mc_done || timeout_now) begin
                        state_d = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                        clr_mem  = 1'b1;
                        tcnt_d   = tcnt_q + TW'(1);
                    end
                end
                default: state_d = RUN;
            endcase

            if (stall_if && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.mc_start  = mc_start;
    assign bus.stall_if  = stall_if;
    assign bus.stall_id  = stall_id;
    assign bus.stall_ex  = stall_ex;
    assign bus.clr_id    = clr_id;
    assign bus.clr_ex    = clr_ex;
    assign bus.clr_mem   = clr_mem;
    assign bus.mc_err    = err_q | timeout_now;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, all compared
// against a cycle-level behavioural model of the controller's rules.
`ifndef PIPE_CTRL_DEFS
`define PIPE_CTRL_DEFS
`define REG_IDX_W 5
`define DEST_SRC_W 2
`define DEST_SRC_MEM 2'd1
`endif

module tb_pipe_ctrl;
    localparam int MC_TIMEOUT = 4;
    localparam int CNT_W      = 3;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model state: busy waiting on the unit, cycles since start, sticky error, counters.
    bit mBusy   = 1'b0;
    int mCycles = 0;
    bit mErr    = 1'b0;
    int mStall  = 0;
    int mFlush  = 0;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit c, input int rs1, input int rs2, input bit u1,
                                 input bit u2, input int src, input int dst, input bit br,
                                 input bit mc, input bit done);
        clr             = c;
        bus.id_rs1      = `REG_IDX_W'(rs1);
        bus.id_rs2      = `REG_IDX_W'(rs2);
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.ex_dest_src = `DEST_SRC_W'(src);
        bus.ex_dest_reg = `REG_IDX_W'(dst);
        bus.ex_br_taken = br;
        bus.ex_mc       = mc;
        bus.mc_done     = done;
    endtask

    // Inputs are already driven at the negedge; check there, then advance the model.
    task automatic runCycle();
        bit lu, eStart, eSIf, eSId, eSEx, eCId, eCEx, eCMem, eErr;
        bit nBusy, nErr;
        int nCycles, nStall, nFlush;
        #1;
        lu = (bus.ex_dest_src == `DEST_SRC_MEM) && (bus.ex_dest_reg != 0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_dest_reg) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_dest_reg));
        {eStart, eSIf, eSId, eSEx, eCId, eCEx, eCMem} = '0;
        eErr = mErr;
        nBusy = mBusy; nCycles = mCycles; nErr = mErr; nStall = mStall; nFlush = mFlush;
        if (clr) begin
            {eCId, eCEx, eCMem} = 3'b111;
            nBusy = 0; nCycles = 0; nErr = 0; nStall = 0; nFlush = 0;
        end else begin
            if (!mBusy) begin
                if (bus.ex_br_taken) begin
                    eCId = 1; eCEx = 1;
                    nFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
                end else if (bus.ex_mc) begin
                    eStart = 1; eSIf = 1; eSId = 1; eSEx = 1; eCMem = 1;
                    nBusy = 1; nCycles = 1;
                end else if (lu) begin
                    eSIf = 1; eSId = 1; eCEx = 1;
                end
            end else if (bus.mc_done) begin
                nBusy = 0;
            end else if (mCycles >= MC_TIMEOUT) begin
                nBusy = 0; nErr = 1; eErr = 1;
            end else begin
                eSIf = 1; eSId = 1; eSEx = 1; eCMem = 1;
                nCycles = mCycles + 1;
            end
            if (eSIf) nStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
        end
        checkOutput("mc_start", bus.mc_start, eStart);
        checkOutput("stall_if", bus.stall_if, eSIf);
        checkOutput("stall_id", bus.stall_id, eSId);
        checkOutput("stall_ex", bus.stall_ex, eSEx);
        checkOutput("clr_id", bus.clr_id, eCId);
        checkOutput("clr_ex", bus.clr_ex, eCEx);
        checkOutput("clr_mem", bus.clr_mem, eCMem);
        checkOutput("mc_err", bus.mc_err, eErr);
        checkOutput("stall_cnt", bus.stall_cnt, mStall);
        checkOutput("flush_cnt", bus.flush_cnt, mFlush);
        @(posedge clk);
        mBusy = nBusy; mCycles = nCycles; mErr = nErr; mStall = nStall; mFlush = nFlush;
        @(negedge clk);
    endtask

    task automatic idle(input bit c);
        applyStimulus(c, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        idle(1);
        runCycle();
    endtask

    initial begin
        idle(1);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        doReset();
        checkOutput("rst_stall_cnt", bus.stall_cnt, 0);
        checkOutput("rst_flush_cnt", bus.flush_cnt, 0);
        checkOutput("rst_mc_err", bus.mc_err, 0);

        // Load-use on rs2: one stall cycle, then clear once the load moves on
        applyStimulus(0, 0, 5, 0, 1, `DEST_SRC_MEM, 5, 0, 0, 0);
        #1 checkOutput("lu_stall_if", bus.stall_if, 1);
        runCycle();
        idle(0);
        runCycle();
        checkOutput("lu_stall_cnt", bus.stall_cnt, 1);

        // Guards: x0 destination and unused rs2 never stall
        applyStimulus(0, 0, 0, 0, 1, `DEST_SRC_MEM, 0, 0, 0, 0);
        #1 checkOutput("guard_x0", bus.stall_if, 0);
        runCycle();
        applyStimulus(0, 0, 5, 0, 0, `DEST_SRC_MEM, 5, 0, 0, 0);
        #1 checkOutput("guard_nouse", bus.stall_if, 0);
        runCycle();

        // Branch beats load-use
        doReset();
        applyStimulus(0, 0, 5, 0, 1, `DEST_SRC_MEM, 5, 1, 0, 0);
        #1 checkOutput("br_clr_id", bus.clr_id, 1);
        checkOutput("br_stall_if", bus.stall_if, 0);
        runCycle();
        checkOutput("br_flush_cnt", bus.flush_cnt, 1);

        // Multi-cycle op completing on cycle 4
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 checkOutput("mc_start_c0", bus.mc_start, 1);
        for (int i = 0; i < 4; i++) runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 checkOutput("mc_done_stall", bus.stall_ex, 0);
        runCycle();
        idle(0);
        runCycle();
        checkOutput("mc_stall_cnt", bus.stall_cnt, 4);

        // Timeout: unit never answers
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) runCycle();
        #1 checkOutput("to_err_c4", bus.mc_err, 1);
        runCycle();
        idle(0);
        for (int i = 0; i < 3; i++) runCycle();
        checkOutput("to_err_sticky", bus.mc_err, 1);
        doReset();
        checkOutput("to_err_cleared", bus.mc_err, 0);

        // Reset in the second wait cycle abandons the op silently
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle();
        runCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 checkOutput("mid_clr_mem", bus.clr_mem, 1);
        checkOutput("mid_stall_if", bus.stall_if, 0);
        runCycle();
        idle(0);
        runCycle();
        checkOutput("mid_cnt", bus.stall_cnt, 0);
        checkOutput("mid_err", bus.mc_err, 0);

        // Flush counter saturation
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) runCycle();
        checkOutput("flush_sat", bus.flush_cnt, CNT_MAX);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) < 2,
                          $urandom_range(3), $urandom_range(3),
                          $urandom_range(1), $urandom_range(1),
                          $urandom_range(3), $urandom_range(3),
                          $urandom_range(99) < 15, $urandom_range(99) < 12,
                          $urandom_range(99) < 20);
            runCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
